sincos_sched: RTL and testbench

Time-multiplexing scheduler that shares one cosine interpolation datapath (14-bit address `a`, sign `s`, `NBO`-bit result, fixed latency) among `NCH` NCO channels. It owns the per-channel phase accumulators and frequency tuning words. On each sample tick it folds every enabled channel's phase into cosine and sine quadrant lookups, issues them round-robin to the datapath, and re-pairs the returning results into aligned cos/sin outputs tagged with the channel number. It sits between the NCO register interface and the shared `cosine_int` instance in the mixer/DDS chain.

---
 rtl/sincos_pkg.sv | 22 ++
 rtl/sincos_fold.sv | 31 +++
 rtl/sincos_sched.sv | 206 ++++++++++++++++++++
 tb/tb_sincos_sched.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sincos_pkg.sv
// Shared widths, constants and types for the sin/cos datapath scheduler.
package sincos_pkg;

    localparam int PW      = 32;
    localparam int AW      = 14;
    localparam int TAG_CHW = 4;

    localparam logic [PW-1:0] QUARTER = 32'h4000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COS,
        ST_SIN
    } state_t;

    typedef struct packed {
        logic               valid;
        logic               is_sin;
        logic [TAG_CHW-1:0] ch;
    } tag_t;

endpackage

// File: rtl/sincos_fold.sv
// Folds a 32-bit phase into a quarter-wave table address plus a negate flag.
module sincos_fold
    import sincos_pkg::*;
(
    input  logic [PW-1:0] phase,
    output logic [AW-1:0] a,
    output logic          s
);

    logic [1:0]    q;
    logic [AW-1:0] i;
    logic          unused_frac;

    assign q           = phase[31:30];
    assign i           = phase[29:16];
    assign unused_frac = ^phase[15:0];

    // NOTE: outputs get defaults before the case so no path can infer a latch.
    always_comb begin
        a = i;
        s = 1'b0;
        case (q)
            2'd0: begin a = i;  s = 1'b0; end
            2'd1: begin a = ~i; s = 1'b1; end
            2'd2: begin a = i;  s = 1'b1; end
            2'd3: begin a = ~i; s = 1'b0; end
            default: ;
        endcase
    end

endmodule

// File: rtl/sincos_sched.sv
// Round-robin scheduler sharing one cosine datapath among NCH NCO channels;
// issues a cos/sin lookup pair per pending channel and re-pairs the results.
module sincos_sched
    import sincos_pkg::*;
#(
    parameter int NCH = 4,
    parameter int LAT = 8,
    parameter int NBO = 23,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  c,
    input  logic                  rst_n,
    input  logic                  cfg_we,
    input  logic                  cfg_clr,
    input  logic [CHW-1:0]        cfg_ch,
    input  logic [31:0]           cfg_ftw,
    input  logic [NCH-1:0]        ch_en,
    input  logic                  tick,
    output logic [AW-1:0]         a,
    output logic                  s,
    input  logic signed [NBO-1:0] d_o,
    output logic                  out_valid,
    output logic [CHW-1:0]        out_ch,
    output logic signed [NBO-1:0] out_cos,
    output logic signed [NBO-1:0] out_sin,
    output logic                  overrun
);

    logic [PW-1:0]  ftw   [NCH];
    logic [PW-1:0]  phase [NCH];
    logic [PW-1:0]  snap  [NCH];
    logic [NCH-1:0] pend;
    logic [NCH-1:0] we_hit, clr_hit;

    state_t         state, state_nxt;
    logic [CHW-1:0] g, g_nxt, last, last_nxt;
    logic [NCH-1:0] g_mask, others;

    logic           issue, iss_sin;
    logic [PW-1:0]  iss_phase;
    logic [AW-1:0]  fold_a;
    logic           fold_s;
    tag_t           iss_tag, ret;
    tag_t           tag_pipe [LAT+1];
    logic signed [NBO-1:0] cos_hold;

    // Lowest-indexed set bit of m, searching upward from after+1 with wrap.
    function automatic logic [CHW-1:0] rr_pick(input logic [NCH-1:0] m, input logic [CHW-1:0] after);
        logic [CHW-1:0] r;
        logic           found;
        int             j;
        r     = after;
        found = 1'b0;
        for (int i = 1; i <= NCH; i++) begin
            j = (int'(after) + i) % NCH;
            if (!found && m[j]) begin
                r     = CHW'(j);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        we_hit  = '0;
        clr_hit = '0;
        for (int k = 0; k < NCH; k++) begin
            we_hit[k]  = cfg_we  && (cfg_ch == CHW'(k));
            clr_hit[k] = cfg_clr && (cfg_ch == CHW'(k));
        end
    end

    // NOTE: the channel arrays are reset explicitly because their zero state is visible on the first tick.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) begin
                ftw[k]   <= '0;
                phase[k] <= '0;
                snap[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (we_hit[k]) ftw[k] <= cfg_ftw;
                if (tick && clr_hit[k]) begin
                    phase[k] <= '0;
                    snap[k]  <= '0;
                end else if (tick) begin
                    phase[k] <= phase[k] + ftw[k];
                    snap[k]  <= phase[k] + ftw[k];
                end else if (clr_hit[k]) begin
                    phase[k] <= '0;
                end
            end
        end
    end

    // A new tick re-arms a channel even while its previous pair is finishing.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            pend    <= '0;
            overrun <= 1'b0;
        end else begin
            if (tick && |(pend & ch_en)) overrun <= 1'b1;
            for (int k = 0; k < NCH; k++) begin
                if (tick && ch_en[k])
                    pend[k] <= 1'b1;
                else if (state == ST_SIN && g == CHW'(k))
                    pend[k] <= 1'b0;
                else if (!ch_en[k] && !(state != ST_IDLE && g == CHW'(k)))
                    pend[k] <= 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            g     <= '0;
            last  <= CHW'(NCH - 1);
        end else begin
            state <= state_nxt;
            g     <= g_nxt;
            last  <= last_nxt;
        end
    end

    assign g_mask = NCH'(1) << g;
    assign others = pend & ~g_mask;

    always_comb begin
        state_nxt = state;
        g_nxt     = g;
        last_nxt  = last;
        case (state)
            ST_IDLE: if (|pend) begin
                state_nxt = ST_COS;
                g_nxt     = rr_pick(pend, last);
            end
            ST_COS:  state_nxt = ST_SIN;
            ST_SIN: begin
                last_nxt = g;
                if (|others) begin
                    state_nxt = ST_COS;
                    g_nxt     = rr_pick(others, g);
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        issue          = (state != ST_IDLE);
        iss_sin        = (state == ST_SIN);
        iss_phase      = iss_sin ? (snap[g] - QUARTER) : snap[g];
        iss_tag        = '0;
        iss_tag.valid  = issue;
        iss_tag.is_sin = iss_sin;
        iss_tag.ch     = TAG_CHW'(g);
    end

    sincos_fold u_fold (
        .phase (iss_phase),
        .a     (fold_a),
        .s     (fold_s)
    );

    // Stage 0 travels with a/s; stage LAT lines up with the matching d_o.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            a <= '0;
            s <= 1'b0;
            for (int i = 0; i <= LAT; i++) tag_pipe[i] <= '0;
        end else begin
            if (issue) begin
                a <= fold_a;
                s <= fold_s;
            end
            tag_pipe[0] <= iss_tag;
            for (int i = 1; i <= LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    assign ret = tag_pipe[LAT];

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            cos_hold  <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_cos   <= '0;
            out_sin   <= '0;
        end else begin
            out_valid <= ret.valid && ret.is_sin;
            if (ret.valid && !ret.is_sin) cos_hold <= d_o;
            if (ret.valid && ret.is_sin) begin
                out_cos <= cos_hold;
                out_sin <= d_o;
                out_ch  <= CHW'(ret.ch);
            end
        end
    end

endmodule

// File: tb/tb_sincos_sched.sv
// Directed bench for sincos_sched with a fixed-latency model datapath.
module tb_sincos_sched;

    localparam int NCH = 4;
    localparam int LAT = 8;
    localparam int NBO = 23;

    logic                  c = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  cfg_we = 1'b0;
    logic                  cfg_clr = 1'b0;
    logic [1:0]            cfg_ch = '0;
    logic [31:0]           cfg_ftw = '0;
    logic [NCH-1:0]        ch_en = '0;
    logic                  tick = 1'b0;
    logic [13:0]           a;
    logic                  s;
    logic signed [NBO-1:0] d_o;
    logic                  out_valid;
    logic [1:0]            out_ch;
    logic signed [NBO-1:0] out_cos;
    logic signed [NBO-1:0] out_sin;
    logic                  overrun;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    int                    q_ch  [$];
    int                    q_cyc [$];
    logic signed [NBO-1:0] q_cos [$];
    logic signed [NBO-1:0] q_sin [$];

    logic signed [NBO-1:0] dp_pipe [LAT];

    sincos_sched #(.NCH(NCH), .LAT(LAT), .NBO(NBO)) dut (
        .c         (c),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_clr   (cfg_clr),
        .cfg_ch    (cfg_ch),
        .cfg_ftw   (cfg_ftw),
        .ch_en     (ch_en),
        .tick      (tick),
        .a         (a),
        .s         (s),
        .d_o       (d_o),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_cos   (out_cos),
        .out_sin   (out_sin),
        .overrun   (overrun)
    );

    always #5 c = ~c;

    always @(posedge c) cyc <= cyc + 1;

    // Datapath model: distinct value per (a, s), LAT cycles after a/s appear.
    function automatic logic signed [NBO-1:0] dp_model(input logic [13:0] aa, input logic ss);
        int v;
        v = int'(aa) + 1;
        return ss ? NBO'(-v) : NBO'(v);
    endfunction

    always @(posedge c) begin
        dp_pipe[0] <= dp_model(a, s);
        for (int i = 1; i < LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
    end
    assign d_o = dp_pipe[LAT-1];

    always @(negedge c) begin
        if (out_valid) begin
            q_ch.push_back(int'(out_ch));
            q_cyc.push_back(cyc);
            q_cos.push_back(out_cos);
            q_sin.push_back(out_sin);
        end
    end

    function automatic logic [14:0] fold_m(input logic [31:0] p);
        logic [13:0] i;
        logic [1:0]  q;
        i = p[29:16];
        q = p[31:30];
        return {q[1] ^ q[0], (q[0] ? ~i : i)};
    endfunction

    function automatic logic signed [NBO-1:0] exp_cos(input logic [31:0] p);
        logic [14:0] f;
        f = fold_m(p);
        return dp_model(f[13:0], f[14]);
    endfunction

    function automatic logic signed [NBO-1:0] exp_sin(input logic [31:0] p);
        return exp_cos(p - 32'h4000_0000);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_pair(input string tag, input int idx, input int ch,
                              input logic [31:0] sv, input int at, input bit chk_val);
        check({tag, "_seen"}, 64'(q_ch.size() > idx), 64'd1);
        if (q_ch.size() > idx) begin
            check({tag, "_ch"},  64'(q_ch[idx]),  64'(ch));
            check({tag, "_cyc"}, 64'(q_cyc[idx]), 64'(at));
            if (chk_val) begin
                check({tag, "_cos"}, 64'(q_cos[idx]), 64'(exp_cos(sv)));
                check({tag, "_sin"}, 64'(q_sin[idx]), 64'(exp_sin(sv)));
            end
        end
    endtask

    task automatic clear_log();
        q_ch.delete();
        q_cyc.delete();
        q_cos.delete();
        q_sin.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ch_en = '0;
        @(negedge c);
        rst_n = 1'b1;
        @(negedge c);
        clear_log();
    endtask

    task automatic cfg_write(input int ch, input logic [31:0] v);
        cfg_we  = 1'b1;
        cfg_ch  = 2'(ch);
        cfg_ftw = v;
        @(negedge c);
        cfg_we  = 1'b0;
    endtask

    // Returns the cycle count seen just after the edge that sampled tick.
    task automatic pulse_tick(input bit clr, input int ch, output int t);
        tick    = 1'b1;
        cfg_clr = clr;
        cfg_ch  = 2'(ch);
        @(negedge c);
        tick    = 1'b0;
        cfg_clr = 1'b0;
        t       = cyc;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_a"},       64'(a),         64'd0);
        check({tag, "_s"},       64'(s),         64'd0);
        check({tag, "_valid"},   64'(out_valid), 64'd0);
        check({tag, "_cos"},     64'(out_cos),   64'd0);
        check({tag, "_sin"},     64'(out_sin),   64'd0);
        check({tag, "_ch"},      64'(out_ch),    64'd0);
        check({tag, "_overrun"}, 64'(overrun),   64'd0);
    endtask

    initial begin
        int t1, t2;
        logic [31:0] f;

        for (int i = 0; i < LAT; i++) dp_pipe[i] = '0;
        repeat (2) @(negedge c);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge c);

        // Single channel, quarter-turn tuning word.
        cfg_write(0, 32'h4000_0000);
        ch_en = 4'b0001;
        pulse_tick(1'b0, 0, t1);
        repeat (2) @(negedge c);
        check("A_cos_a", 64'(a), 64'h3FFF);
        check("A_cos_s", 64'(s), 64'd1);
        @(negedge c);
        check("A_sin_a", 64'(a), 64'h0000);
        check("A_sin_s", 64'(s), 64'd0);
        repeat (20) @(negedge c);
        check("A_count", 64'(q_ch.size()), 64'd1);
        check_pair("A", 0, 0, 32'h4000_0000, t1 + 12, 1'b1);
        if (q_cos.size() > 0) begin
            check("A_cos_val", 64'(q_cos[0]), 64'(-16384));
            check("A_sin_val", 64'(q_sin[0]), 64'd1);
        end

        // Four channels, ticks 10 cycles apart: no overrun.
        do_reset();
        for (int k = 0; k < NCH; k++) cfg_write(k, 32'(k + 1) << 28);
        ch_en = 4'b1111;
        pulse_tick(1'b0, 0, t1);
        repeat (9) @(negedge c);
        pulse_tick(1'b0, 0, t2);
        check("B_tick_gap", 64'(t2 - t1), 64'd10);
        repeat (40) @(negedge c);
        check("B_count", 64'(q_ch.size()), 64'd8);
        check("B_overrun", 64'(overrun), 64'd0);
        for (int k = 0; k < NCH; k++) begin
            f = 32'(k + 1) << 28;
            check_pair($sformatf("B1_%0d", k), k,     k, f,      t1 + 12 + 2 * k, 1'b1);
            check_pair($sformatf("B2_%0d", k), k + 4, k, f << 1, t2 + 12 + 2 * k, 1'b1);
        end

        // Same channels, ticks 6 cycles apart: second tick overruns.
        do_reset();
        for (int k = 0; k < NCH; k++) cfg_write(k, 32'(k + 1) << 28);
        ch_en = 4'b1111;
        pulse_tick(1'b0, 0, t1);
        repeat (5) @(negedge c);
        check("C_overrun_pre", 64'(overrun), 64'd0);
        pulse_tick(1'b0, 0, t2);
        check("C_overrun_post", 64'(overrun), 64'd1);
        repeat (40) @(negedge c);
        check("C_count", 64'(q_ch.size()), 64'd6);
        check_pair("C0", 0, 0, 32'h1000_0000, t1 + 12, 1'b1);
        check_pair("C1", 1, 1, 32'h2000_0000, t1 + 14, 1'b1);
        check_pair("C2", 2, 2, 32'h0,         t1 + 16, 1'b0);
        check_pair("C3", 3, 3, 32'h8000_0000, t1 + 18, 1'b1);
        check_pair("C4", 4, 0, 32'h2000_0000, t1 + 20, 1'b1);
        check_pair("C5", 5, 1, 32'h4000_0000, t1 + 22, 1'b1);
        check("C_overrun_sticky", 64'(overrun), 64'd1);

        // Clear coinciding with tick on channel 2.
        do_reset();
        cfg_write(2, 32'h1234_5678);
        ch_en = 4'b0100;
        pulse_tick(1'b0, 0, t1);
        repeat (20) @(negedge c);
        pulse_tick(1'b1, 2, t2);
        repeat (2) @(negedge c);
        check("D_cos_a", 64'(a), 64'h0000);
        check("D_cos_s", 64'(s), 64'd0);
        @(negedge c);
        check("D_sin_a", 64'(a), 64'h3FFF);
        check("D_sin_s", 64'(s), 64'd0);
        repeat (20) @(negedge c);
        check("D_count", 64'(q_ch.size()), 64'd2);
        check_pair("D0", 0, 2, 32'h1234_5678, t1 + 12, 1'b1);
        check_pair("D1", 1, 2, 32'h0,         t2 + 12, 1'b1);
        if (q_cos.size() > 1) begin
            check("D_cos_val", 64'(q_cos[1]), 64'd1);
            check("D_sin_val", 64'(q_sin[1]), 64'h4000);
        end

        // All-ones tuning word wraps the phase to 0xFFFF_FFFE.
        do_reset();
        cfg_write(1, 32'hFFFF_FFFF);
        ch_en = 4'b0010;
        pulse_tick(1'b0, 0, t1);
        repeat (14) @(negedge c);
        pulse_tick(1'b0, 0, t2);
        repeat (2) @(negedge c);
        check("E_cos_a", 64'(a), 64'h0000);
        check("E_cos_s", 64'(s), 64'd0);
        @(negedge c);
        check("E_sin_a", 64'(a), 64'h3FFF);
        check("E_sin_s", 64'(s), 64'd1);
        repeat (20) @(negedge c);
        check_pair("E1", 1, 1, 32'hFFFF_FFFE, t2 + 12, 1'b1);
        if (q_cos.size() > 1) begin
            check("E_cos_val", 64'(q_cos[1]), 64'd1);
            check("E_sin_val", 64'(q_sin[1]), 64'(-16384));
        end

        // Reset between the COS and SIN issue of a pair.
        pulse_tick(1'b0, 0, t1);
        @(negedge c);
        pulse_tick(1'b0, 0, t2);
        check("F_overrun_pre", 64'(overrun), 64'd1);
        check("F_out_pre", 64'(out_cos != 0), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("F_rst");
        clear_log();
        @(negedge c);
        rst_n = 1'b1;
        repeat (30) @(negedge c);
        check("F_no_valid", 64'(q_ch.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
